// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter: default widths,
// the hard-wired zero register and the writeback request bundle.
package regfile_pkg;

   localparam int DATA_W_DEF = 32'sd32;
   localparam int ADDR_W_DEF = 32'sd5;
   localparam int CNT_W_DEF  = 32'sd8;

   localparam int ZERO_REG   = 32'sd0;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
   } wb_req_t;

endpackage : regfile_pkg

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the two writeback requesters, the arbiter and the
// register-file write port. The master side drives requests and stall.
interface regfile_wb_arbiter_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
);

   logic              a_valid;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;
   logic              b_valid;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;
   logic              stall;
   logic              grant_b;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [CNT_W-1:0]  conflict_cnt;

   modport master (
      output a_valid, a_addr, a_data, b_valid, b_addr, b_data, stall,
      input  a_ready, b_ready, grant_b, rf_we, rf_waddr, rf_wdata, conflict_cnt
   );

   modport slave (
      input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, stall,
      output a_ready, b_ready, grant_b, rf_we, rf_waddr, rf_wdata, conflict_cnt
   );

endinterface : regfile_wb_arbiter_if

// File: rtl/wb_sel_mux.sv
// Pure 2:1 select of the writeback address/data pair feeding the
// arbiter's output register.
module wb_sel_mux #(
   parameter int DATA_W = 32'sd32,
   parameter int ADDR_W = 32'sd5
) (
   input  logic              sel_b_i,
   input  logic [ADDR_W-1:0] a_addr_i,
   input  logic [DATA_W-1:0] a_data_i,
   input  logic [ADDR_W-1:0] b_addr_i,
   input  logic [DATA_W-1:0] b_data_i,
   output logic [ADDR_W-1:0] sel_addr_o,
   output logic [DATA_W-1:0] sel_data_o
);

   assign sel_addr_o = sel_b_i ? b_addr_i : a_addr_i;
   assign sel_data_o = sel_b_i ? b_data_i : a_data_i;

endmodule : wb_sel_mux

// File: rtl/regfile_wb_arbiter.sv
// Two-requester writeback arbiter for the register-file write port.
// Define WB_ARB_RR_EN for round-robin on contention; otherwise A has fixed priority.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_wb_arbiter_if.slave  bus
);

   logic              both_req;
   logic              pick_b;
   logic              a_ready;
   logic              b_ready;
   logic              xfer;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   logic              rf_we_q,    rf_we_d;
   logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
   logic              grant_b_q,  grant_b_d;
   logic              last_b_q,   last_b_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;

   assign both_req = bus.a_valid & bus.b_valid;

`ifdef WB_ARB_RR_EN
   assign pick_b = both_req ? ~last_b_q : bus.b_valid;
`else
   assign pick_b = ~bus.a_valid & bus.b_valid;
`endif

   // Readies are held low during reset so pending requests are dropped.
   assign a_ready = rst_n & ~bus.stall & bus.a_valid & ~pick_b;
   assign b_ready = rst_n & ~bus.stall & bus.b_valid &  pick_b;
   assign xfer    = a_ready | b_ready;

   wb_sel_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_sel (
      .sel_b_i    (pick_b),
      .a_addr_i   (bus.a_addr),
      .a_data_i   (bus.a_data),
      .b_addr_i   (bus.b_addr),
      .b_data_i   (bus.b_data),
      .sel_addr_o (sel_addr),
      .sel_data_o (sel_data)
   );

   // Next-state for the write register, priority state and contention counter.
   always_comb begin
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      grant_b_d  = grant_b_q;
      last_b_d   = last_b_q;
      cnt_d      = cnt_q;
      if (xfer) begin
         rf_we_d    = (sel_addr != ADDR_W'(ZERO_REG));
         rf_waddr_d = sel_addr;
         rf_wdata_d = sel_data;
         grant_b_d  = pick_b;
         last_b_d   = pick_b;
      end else begin
         rf_we_d    = 1'b0;
      end
      if (both_req && !bus.stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1'b1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers with synchronous active-low reset; A wins first contention.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         grant_b_q  <= 1'b0;
         last_b_q   <= 1'b1;
         cnt_q      <= '0;
      end else begin
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         grant_b_q  <= grant_b_d;
         last_b_q   <= last_b_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.a_ready      = a_ready;
   assign bus.b_ready      = b_ready;
   assign bus.grant_b      = grant_b_q;
   assign bus.rf_we        = rf_we_q;
   assign bus.rf_waddr     = rf_waddr_q;
   assign bus.rf_wdata     = rf_wdata_q;
   assign bus.conflict_cnt = cnt_q;

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter with a transaction-level reference
// model; honours WB_ARB_RR_EN the same way as the design.
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   localparam int DW      = 32;
   localparam int AW      = 5;
   localparam int CW      = 8;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

   regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state: what the write port should show, and who won last
   logic          m_we      = 1'b0;
   logic [AW-1:0] m_waddr   = '0;
   logic [DW-1:0] m_wdata   = '0;
   logic          m_grant_b = 1'b0;
   int            m_cnt     = 0;
   int            m_last    = 1;
   int            exp_win   = -1;

   // -1 = nobody, 0 = A, 1 = B
   function automatic int winner();
      if (!rst_n || bus.stall) return -1;
      if (bus.a_valid && bus.b_valid) begin
`ifdef WB_ARB_RR_EN
         return (m_last == 1) ? 0 : 1;
`else
         return 0;
`endif
      end
      if (bus.a_valid) return 0;
      if (bus.b_valid) return 1;
      return -1;
   endfunction

   task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                        input logic st);
      bus.a_valid = av; bus.a_addr = aa; bus.a_data = ad;
      bus.b_valid = bv; bus.b_addr = ba; bus.b_data = bd;
      bus.stall   = st;
   endtask

   task automatic settle();
      @(negedge clk);
      exp_win = winner();
   endtask

   task automatic tick(output int win);
      wb_req_t req;
      @(posedge clk);
      win = winner();
      if (!rst_n) begin
         m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_grant_b = 1'b0; m_cnt = 0; m_last = 1;
      end else begin
         if (bus.a_valid && bus.b_valid && !bus.stall)
            m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
         if (win < 0) begin
            m_we = 1'b0;
         end else begin
            if (win == 1) begin req.addr = bus.b_addr; req.data = bus.b_data; end
            else          begin req.addr = bus.a_addr; req.data = bus.a_data; end
            m_waddr   = req.addr;
            m_wdata   = req.data;
            m_we      = (int'(req.addr) != ZERO_REG);
            m_grant_b = (win == 1);
            m_last    = win;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      int w;
      rst_n = 1'b0;
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0);
      for (int i = 0; i < 2; i++) begin
         settle();
         n_checks++;
         if ({bus.a_ready, bus.b_ready} !== 2'b00)
            $display("FAIL reset_ready: got %b%b want 00", bus.a_ready, bus.b_ready);
         else n_pass++;
         tick(w);
         n_checks++;
         if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.grant_b, bus.conflict_cnt} !== '0)
            $display("FAIL reset_outputs: got we=%0b addr=%0d data=%h gb=%0b cnt=%0d want all zero",
                     bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.grant_b, bus.conflict_cnt);
         else n_pass++;
      end
      rst_n = 1'b1;
      n_checks++;
      if (bus.rf_we !== 1'b0) $display("FAIL reset_release_we: got %0b want 0", bus.rf_we);
      else n_pass++;
      settle();
      n_checks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b10)
         $display("FAIL reset_first_grant: got %b%b want 10", bus.a_ready, bus.b_ready);
      else n_pass++;
      tick(w);
      n_checks++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.grant_b} !== {1'b1, 5'd1, 32'h11, 1'b0})
         $display("FAIL reset_first_write: got we=%0b addr=%0d data=%h gb=%0b want 1/1/11/0",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.grant_b);
      else n_pass++;
   endtask

   task automatic test_single();
      int w;
      drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
      settle();
      n_checks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b10)
         $display("FAIL single_ready: got %b%b want 10", bus.a_ready, bus.b_ready);
      else n_pass++;
      tick(w);
      n_checks++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.grant_b} !== {1'b1, 5'd3, 32'hDEADBEEF, 1'b0})
         $display("FAIL single_write: got we=%0b addr=%0d data=%h gb=%0b want 1/3/deadbeef/0",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.grant_b);
      else n_pass++;
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
      settle();
      tick(w);
      n_checks++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b0, 5'd3, 32'hDEADBEEF})
         $display("FAIL single_hold: got we=%0b addr=%0d data=%h want 0/3/deadbeef",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata);
      else n_pass++;
   endtask

   task automatic test_contention();
      int w;
      logic exp_gb;
      rst_n = 1'b0;
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0);
      tick(w);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
`ifdef WB_ARB_RR_EN
         exp_gb = (i % 2 == 1);
`else
         exp_gb = 1'b0;
`endif
         settle();
         n_checks++;
         if ({bus.a_ready, bus.b_ready} !== {~exp_gb, exp_gb})
            $display("FAIL contention_ready[%0d]: got %b%b want %b%b", i, bus.a_ready, bus.b_ready, ~exp_gb, exp_gb);
         else n_pass++;
         tick(w);
         n_checks++;
         if ({bus.rf_we, bus.grant_b, bus.rf_waddr} !== {1'b1, exp_gb, exp_gb ? 5'd2 : 5'd1})
            $display("FAIL contention_write[%0d]: got we=%0b gb=%0b addr=%0d want gb=%0b",
                     i, bus.rf_we, bus.grant_b, bus.rf_waddr, exp_gb);
         else n_pass++;
      end
      n_checks++;
      if (bus.conflict_cnt !== 8'd4) $display("FAIL contention_cnt: got %0d want 4", bus.conflict_cnt);
      else n_pass++;
   endtask

   task automatic test_zero_reg();
      int w;
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
      settle();
      n_checks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b01)
         $display("FAIL zero_ready: got %b%b want 01", bus.a_ready, bus.b_ready);
      else n_pass++;
      tick(w);
      n_checks++;
      if ({bus.rf_we, bus.grant_b, bus.rf_waddr} !== {1'b0, 1'b1, 5'd0})
         $display("FAIL zero_write: got we=%0b gb=%0b addr=%0d want 0/1/0", bus.rf_we, bus.grant_b, bus.rf_waddr);
      else n_pass++;
   endtask

   task automatic test_stall();
      int w;
      drive(1'b1, 5'd7, 32'hA5A5_0F0F, 1'b0, 5'd0, 32'd0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         settle();
         n_checks++;
         if ({bus.a_ready, bus.b_ready} !== 2'b00)
            $display("FAIL stall_ready[%0d]: got %b%b want 00", i, bus.a_ready, bus.b_ready);
         else n_pass++;
         tick(w);
         n_checks++;
         if (bus.rf_we !== 1'b0) $display("FAIL stall_we[%0d]: got %0b want 0", i, bus.rf_we);
         else n_pass++;
      end
      bus.stall = 1'b0;
      settle();
      n_checks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b10)
         $display("FAIL stall_release_ready: got %b%b want 10", bus.a_ready, bus.b_ready);
      else n_pass++;
      tick(w);
      n_checks++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== {1'b1, 5'd7, 32'hA5A5_0F0F})
         $display("FAIL stall_release_write: got we=%0b addr=%0d data=%h want 1/7/a5a50f0f",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata);
      else n_pass++;
   endtask

   task automatic test_saturation();
      int w;
      rst_n = 1'b0;
      drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd5, 32'h55, 1'b0);
      tick(w);
      rst_n = 1'b1;
      for (int i = 0; i < 300; i++) begin
         tick(w);
         if (i == 253) begin
            n_checks++;
            if (bus.conflict_cnt !== 8'd254) $display("FAIL sat_before: got %0d want 254", bus.conflict_cnt);
            else n_pass++;
         end
      end
      n_checks++;
      if (bus.conflict_cnt !== 8'd255) $display("FAIL sat_final: got %0d want 255", bus.conflict_cnt);
      else n_pass++;
   endtask

   task automatic test_mid_reset();
      int w;
      drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 1'b0);
      for (int i = 0; i < 3; i++) tick(w);
      rst_n = 1'b0;
      settle();
      n_checks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b00)
         $display("FAIL midrst_ready: got %b%b want 00", bus.a_ready, bus.b_ready);
      else n_pass++;
      tick(w);
      rst_n = 1'b1;
      n_checks++;
      if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.grant_b, bus.conflict_cnt} !== '0)
         $display("FAIL midrst_outputs: got we=%0b addr=%0d data=%h gb=%0b cnt=%0d want all zero",
                  bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.grant_b, bus.conflict_cnt);
      else n_pass++;
      settle();
      n_checks++;
      if ({bus.a_ready, bus.b_ready} !== 2'b10)
         $display("FAIL midrst_grant: got %b%b want 10", bus.a_ready, bus.b_ready);
      else n_pass++;
      tick(w);
   endtask

   task automatic test_random();
      int            w;
      logic          av, bv;
      logic [AW-1:0] aa, ba;
      logic [DW-1:0] ad, bd;
      av = 1'b0; bv = 1'b0; aa = '0; ba = '0; ad = '0; bd = '0;
      for (int i = 0; i < 400; i++) begin
         if (!av && $urandom_range(0, 3) != 0) begin
            av = 1'b1; aa = AW'($urandom_range(0, 31)); ad = $urandom;
         end
         if (!bv && $urandom_range(0, 3) != 0) begin
            bv = 1'b1; ba = AW'($urandom_range(0, 31)); bd = $urandom;
            if ($urandom_range(0, 3) == 0) ba = aa;
         end
         drive(av, aa, ad, bv, ba, bd, ($urandom_range(0, 4) == 0));
         settle();
         n_checks++;
         if ({bus.a_ready, bus.b_ready} !== {exp_win == 0, exp_win == 1})
            $display("FAIL rand_ready[%0d]: got %b%b want %b%b", i, bus.a_ready, bus.b_ready,
                     exp_win == 0, exp_win == 1);
         else n_pass++;
         tick(w);
         n_checks++;
         if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.grant_b, bus.conflict_cnt} !==
             {m_we, m_waddr, m_wdata, m_grant_b, CW'(m_cnt)})
            $display("FAIL rand_out[%0d]: got we=%0b addr=%0d data=%h gb=%0b cnt=%0d want we=%0b addr=%0d data=%h gb=%0b cnt=%0d",
                     i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.grant_b, bus.conflict_cnt,
                     m_we, m_waddr, m_wdata, m_grant_b, m_cnt);
         else n_pass++;
         if (w == 0) av = 1'b0;
         if (w == 1) bv = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_zero_reg();
      test_stall();
      test_saturation();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1);
   end

endmodule : tb_regfile_wb_arbiter
